// File: rtl/ysyx_23060184_mem_arbiter.sv
// ----------------------------------------------------------------------------
// ysyx_23060184_mem_arbiter
//
// Shares one memory port between the instruction fetch unit (IFU) and the
// load/store unit (LSU). Exactly one transaction is in flight at a time; when
// both masters request in the same cycle the master that did not own the most
// recent transaction wins (round-robin).
//
// Transaction flow: IDLE (accept) -> ISSUE (mem request) -> WAIT (mem response)
// -> RESP (one-cycle response pulse to the owner) -> IDLE.
//
// Ports
//   clk, reset                    : single clock, asynchronous active-high reset
//   ifu_req_valid/ready, ifu_addr : IFU fetch request channel
//   ifu_resp_valid, ifu_rdata     : IFU response (one-cycle pulse)
//   lsu_req_valid/ready, lsu_addr,
//   lsu_wen, lsu_wdata, lsu_wmask : LSU load/store request channel
//   lsu_resp_valid, lsu_rdata     : LSU response (one-cycle pulse)
//   mem_req_*, mem_addr, mem_wen,
//   mem_wdata, mem_wmask          : memory request channel (driven from buffer)
//   mem_resp_valid, mem_rdata     : memory response channel
//   owner                         : owner of current/last transaction (0=IFU, 1=LSU)
// ----------------------------------------------------------------------------
module ysyx_23060184_mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int MASK_W = DATA_W / 8
) (
   input  logic              clk,
   input  logic              reset,
   // IFU
   input  logic              ifu_req_valid,
   output logic              ifu_req_ready,
   input  logic [ADDR_W-1:0] ifu_addr,
   output logic              ifu_resp_valid,
   output logic [DATA_W-1:0] ifu_rdata,
   // LSU
   input  logic              lsu_req_valid,
   output logic              lsu_req_ready,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic              lsu_wen,
   input  logic [DATA_W-1:0] lsu_wdata,
   input  logic [MASK_W-1:0] lsu_wmask,
   output logic              lsu_resp_valid,
   output logic [DATA_W-1:0] lsu_rdata,
   // Memory
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wen,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [MASK_W-1:0] mem_wmask,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_rdata,
   // Status
   output logic              owner
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic              owner_r;
   logic [ADDR_W-1:0] req_addr_r;
   logic              req_wen_r;
   logic [DATA_W-1:0] req_wdata_r;
   logic [MASK_W-1:0] req_wmask_r;
   logic [DATA_W-1:0] resp_data_r;

   logic              ifu_grant_s;
   logic              lsu_grant_s;
   logic              ifu_hs_s;
   logic              lsu_hs_s;

   // Arbitration: grants are only offered in IDLE; on contention the master
   // that did not own the last transaction wins.
   always_comb begin
      ifu_grant_s = 1'b0;
      lsu_grant_s = 1'b0;
      if (state_r == ST_IDLE) begin
         if (ifu_req_valid && lsu_req_valid) begin
            ifu_grant_s = owner_r;
            lsu_grant_s = ~owner_r;
         end else if (ifu_req_valid) begin
            ifu_grant_s = 1'b1;
         end else if (lsu_req_valid) begin
            lsu_grant_s = 1'b1;
         end else begin
            ifu_grant_s = 1'b0;
            lsu_grant_s = 1'b0;
         end
      end else begin
         ifu_grant_s = 1'b0;
         lsu_grant_s = 1'b0;
      end
   end

   assign ifu_req_ready = ifu_grant_s;
   assign lsu_req_ready = lsu_grant_s;
   assign ifu_hs_s      = ifu_req_valid & ifu_grant_s;
   assign lsu_hs_s      = lsu_req_valid & lsu_grant_s;

   // Next-state logic for the transaction FSM
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (ifu_hs_s || lsu_hs_s) begin
               state_nxt_s = ST_ISSUE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (mem_req_ready) begin
               state_nxt_s = ST_WAIT;
            end else begin
               state_nxt_s = ST_ISSUE;
            end
         end
         ST_WAIT: begin
            if (mem_resp_valid) begin
               state_nxt_s = ST_RESP;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_RESP: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Request buffer and owner: captured on handshake so later changes on the
   // master inputs cannot disturb the memory request. IFU requests are reads.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner_r     <= 1'b0;
         req_addr_r  <= {ADDR_W{1'b0}};
         req_wen_r   <= 1'b0;
         req_wdata_r <= {DATA_W{1'b0}};
         req_wmask_r <= {MASK_W{1'b0}};
      end else if (lsu_hs_s) begin
         owner_r     <= 1'b1;
         req_addr_r  <= lsu_addr;
         req_wen_r   <= lsu_wen;
         req_wdata_r <= lsu_wdata;
         req_wmask_r <= lsu_wmask;
      end else if (ifu_hs_s) begin
         owner_r     <= 1'b0;
         req_addr_r  <= ifu_addr;
         req_wen_r   <= 1'b0;
         req_wdata_r <= {DATA_W{1'b0}};
         req_wmask_r <= {MASK_W{1'b0}};
      end else begin
         owner_r     <= owner_r;
         req_addr_r  <= req_addr_r;
         req_wen_r   <= req_wen_r;
         req_wdata_r <= req_wdata_r;
         req_wmask_r <= req_wmask_r;
      end
   end

   // Response buffer: only a response arriving in WAIT is taken; stray
   // responses in any other state leave it untouched.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         resp_data_r <= {DATA_W{1'b0}};
      end else if ((state_r == ST_WAIT) && mem_resp_valid) begin
         resp_data_r <= mem_rdata;
      end else begin
         resp_data_r <= resp_data_r;
      end
   end

   // All outputs below decode registered state only.
   assign mem_req_valid  = (state_r == ST_ISSUE);
   assign mem_addr       = req_addr_r;
   assign mem_wen        = req_wen_r;
   assign mem_wdata      = req_wdata_r;
   assign mem_wmask      = req_wmask_r;

   assign ifu_resp_valid = (state_r == ST_RESP) & ~owner_r;
   assign lsu_resp_valid = (state_r == ST_RESP) &  owner_r;
   assign ifu_rdata      = resp_data_r;
   assign lsu_rdata      = resp_data_r;
   assign owner          = owner_r;

endmodule

// File: tb/tb_ysyx_23060184_mem_arbiter.sv
// ----------------------------------------------------------------------------
// Directed testbench for ysyx_23060184_mem_arbiter. Inputs change 2 time units
// after the rising edge; outputs are checked 1 time unit later.
// ----------------------------------------------------------------------------
module tb_ysyx_23060184_mem_arbiter;

   logic        clk;
   logic        reset;
   logic        ifu_req_valid;
   logic        ifu_req_ready;
   logic [31:0] ifu_addr;
   logic        ifu_resp_valid;
   logic [31:0] ifu_rdata;
   logic        lsu_req_valid;
   logic        lsu_req_ready;
   logic [31:0] lsu_addr;
   logic        lsu_wen;
   logic [31:0] lsu_wdata;
   logic [3:0]  lsu_wmask;
   logic        lsu_resp_valid;
   logic [31:0] lsu_rdata;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_addr;
   logic        mem_wen;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_resp_valid;
   logic [31:0] mem_rdata;
   logic        owner;

   int errors = 0;
   int checks = 0;

   ysyx_23060184_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MASK_W(4)) dut (
      .clk(clk), .reset(reset),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
      .ifu_addr(ifu_addr), .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
      .lsu_addr(lsu_addr), .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata),
      .lsu_wmask(lsu_wmask), .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
      .owner(owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard time limit so the run can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      ifu_req_valid = 1'b0; ifu_addr = 32'h0;
      lsu_req_valid = 1'b0; lsu_addr = 32'h0; lsu_wen = 1'b0;
      lsu_wdata = 32'h0; lsu_wmask = 4'h0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'h0;
      #1;
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_req_valid: got %b want 0", mem_req_valid); end
      checks++; if (owner !== 1'b0) begin errors++; $display("FAIL reset_owner: got %b want 0", owner); end
      checks++; if ({ifu_resp_valid, lsu_resp_valid} !== 2'b00) begin errors++; $display("FAIL reset_resp_valid: got %b want 00", {ifu_resp_valid, lsu_resp_valid}); end
      checks++; if (ifu_rdata !== 32'h0 || mem_addr !== 32'h0) begin errors++; $display("FAIL reset_buffers: rdata %h addr %h want 0", ifu_rdata, mem_addr); end
      tick(); tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_single_fetch();
      // cycle N: accept
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000; mem_req_ready = 1'b1;
      #1;
      checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin errors++; $display("FAIL fetch_ready: got %b want 10", {ifu_req_ready, lsu_req_ready}); end
      tick();
      // N+1: issue; inputs scrambled to show the buffer holds the request
      ifu_req_valid = 1'b0; ifu_addr = 32'h1234_5678;
      #1;
      checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL fetch_issue_valid: got %b want 1", mem_req_valid); end
      checks++; if (mem_addr !== 32'h8000_0000 || mem_wen !== 1'b0 || mem_wmask !== 4'h0) begin errors++; $display("FAIL fetch_issue_fields: addr %h wen %b mask %h want 80000000 0 0", mem_addr, mem_wen, mem_wmask); end
      tick();
      // N+2: wait, memory answers immediately
      mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0413;
      #1;
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL fetch_wait_req_valid: got %b want 0", mem_req_valid); end
      tick();
      // N+3: response pulse
      mem_resp_valid = 1'b0; mem_rdata = 32'hFFFF_FFFF;
      #1;
      checks++; if ({ifu_resp_valid, lsu_resp_valid} !== 2'b10) begin errors++; $display("FAIL fetch_resp_pulse: got %b want 10", {ifu_resp_valid, lsu_resp_valid}); end
      checks++; if (ifu_rdata !== 32'h0000_0413 || lsu_rdata !== 32'h0000_0413) begin errors++; $display("FAIL fetch_rdata: ifu %h lsu %h want 00000413", ifu_rdata, lsu_rdata); end
      tick();
      // N+4: back in IDLE
      #1;
      checks++; if (ifu_resp_valid !== 1'b0) begin errors++; $display("FAIL fetch_pulse_width: got %b want 0", ifu_resp_valid); end
   endtask

   task automatic test_contention();
      logic exp_lsu;
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
      lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0200; lsu_wen = 1'b0;
      mem_req_ready = 1'b1; mem_resp_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp_lsu = ((k % 2) == 0);
         mem_rdata = 32'h0000_1000 + k;
         #1;
         checks++; if ({ifu_req_ready, lsu_req_ready} !== {~exp_lsu, exp_lsu}) begin errors++; $display("FAIL contend_ready[%0d]: got %b want %b", k, {ifu_req_ready, lsu_req_ready}, {~exp_lsu, exp_lsu}); end
         tick();
         #1;
         checks++; if (owner !== exp_lsu) begin errors++; $display("FAIL contend_owner[%0d]: got %b want %b", k, owner, exp_lsu); end
         checks++; if (mem_req_valid !== 1'b1 || mem_addr !== (exp_lsu ? 32'h8000_0200 : 32'h8000_0100)) begin errors++; $display("FAIL contend_issue[%0d]: valid %b addr %h", k, mem_req_valid, mem_addr); end
         checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b00) begin errors++; $display("FAIL contend_busy_ready[%0d]: got %b want 00", k, {ifu_req_ready, lsu_req_ready}); end
         tick();
         tick();
         #1;
         checks++; if ({ifu_resp_valid, lsu_resp_valid} !== {~exp_lsu, exp_lsu}) begin errors++; $display("FAIL contend_resp[%0d]: got %b want %b", k, {ifu_resp_valid, lsu_resp_valid}, {~exp_lsu, exp_lsu}); end
         checks++; if (ifu_rdata !== 32'h0000_1000 + k) begin errors++; $display("FAIL contend_rdata[%0d]: got %h want %h", k, ifu_rdata, 32'h0000_1000 + k); end
         checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b00) begin errors++; $display("FAIL contend_resp_ready[%0d]: got %b want 00", k, {ifu_req_ready, lsu_req_ready}); end
         tick();
      end
      ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_resp_valid = 1'b0;
      tick();
   endtask

   task automatic test_backpressure();
      lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
      lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
      #1;
      checks++; if (lsu_req_ready !== 1'b1) begin errors++; $display("FAIL bp_accept: got %b want 1", lsu_req_ready); end
      tick();
      lsu_req_valid = 1'b0; lsu_addr = 32'h0; lsu_wen = 1'b0; lsu_wdata = 32'h0; lsu_wmask = 4'h0;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_1000 || mem_wen !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF || mem_wmask !== 4'hF) begin errors++; $display("FAIL bp_hold[%0d]: valid %b addr %h wen %b data %h mask %h", i, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask); end
         tick();
      end
      mem_req_ready = 1'b1;
      #1;
      checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL bp_still_issue: got %b want 1", mem_req_valid); end
      tick();
      mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h0BAD_F00D;
      tick();
      mem_resp_valid = 1'b0;
      #1;
      checks++; if ({ifu_resp_valid, lsu_resp_valid} !== 2'b01) begin errors++; $display("FAIL bp_resp: got %b want 01", {ifu_resp_valid, lsu_resp_valid}); end
      tick();
      #1;
      checks++; if (lsu_resp_valid !== 1'b0) begin errors++; $display("FAIL bp_single_pulse: got %b want 0", lsu_resp_valid); end
   endtask

   task automatic test_slow_response();
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0004; mem_req_ready = 1'b1;
      tick();
      ifu_req_valid = 1'b0;
      tick();
      for (int i = 0; i < 10; i++) begin
         #1;
         checks++; if ({ifu_resp_valid, lsu_resp_valid, mem_req_valid} !== 3'b000) begin errors++; $display("FAIL slow_wait[%0d]: got %b want 000", i, {ifu_resp_valid, lsu_resp_valid, mem_req_valid}); end
         tick();
      end
      mem_resp_valid = 1'b1; mem_rdata = 32'hCAFE_0001;
      tick();
      mem_resp_valid = 1'b0;
      #1;
      checks++; if (ifu_resp_valid !== 1'b1 || ifu_rdata !== 32'hCAFE_0001) begin errors++; $display("FAIL slow_resp: valid %b data %h want 1 cafe0001", ifu_resp_valid, ifu_rdata); end
      tick();
      // Stray responses while idle
      mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0055;
      for (int i = 0; i < 3; i++) begin
         tick();
         #1;
         checks++; if ({ifu_resp_valid, lsu_resp_valid, mem_req_valid} !== 3'b000 || ifu_rdata !== 32'hCAFE_0001) begin errors++; $display("FAIL spurious[%0d]: flags %b data %h", i, {ifu_resp_valid, lsu_resp_valid, mem_req_valid}, ifu_rdata); end
      end
      mem_resp_valid = 1'b0;
      ifu_req_valid = 1'b1;
      #1;
      checks++; if (ifu_req_ready !== 1'b1) begin errors++; $display("FAIL spurious_idle: got %b want 1", ifu_req_ready); end
      ifu_req_valid = 1'b0;
      tick();
   endtask

   task automatic test_reset_in_wait();
      lsu_req_valid = 1'b1; lsu_addr = 32'h8000_2000; lsu_wen = 1'b0; mem_req_ready = 1'b1;
      tick();
      lsu_req_valid = 1'b0;
      tick();
      #1;
      checks++; if (owner !== 1'b1) begin errors++; $display("FAIL rst_pre_owner: got %b want 1", owner); end
      reset = 1'b1;
      #1;
      checks++; if (mem_req_valid !== 1'b0 || owner !== 1'b0 || mem_addr !== 32'h0 || ifu_rdata !== 32'h0) begin errors++; $display("FAIL rst_async: valid %b owner %b addr %h data %h", mem_req_valid, owner, mem_addr, ifu_rdata); end
      tick();
      reset = 1'b0;
      mem_resp_valid = 1'b1; mem_rdata = 32'h7777_7777;
      for (int i = 0; i < 3; i++) begin
         tick();
         #1;
         checks++; if ({ifu_resp_valid, lsu_resp_valid} !== 2'b00 || ifu_rdata !== 32'h0) begin errors++; $display("FAIL rst_late_resp[%0d]: pulses %b data %h", i, {ifu_resp_valid, lsu_resp_valid}, ifu_rdata); end
      end
      mem_resp_valid = 1'b0;
      ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
      #1;
      checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin errors++; $display("FAIL rst_first_grant: got %b want 01", {ifu_req_ready, lsu_req_ready}); end
      ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_contention();
      test_backpressure();
      test_slow_response();
      test_reset_in_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
